// File: rtl/fpga_mode_pkg.sv
// fpga_mode_pkg: shared definitions for the HF/LF personality sequencer.
//   seq_state_e  : sequencer states (IDLE, DEBOUNCE, DRAIN, SWITCH, SETTLE)
//   MODE_HF/LF   : mux select encodings (1 = HF, 0 = LF)
//   CNT_W, cnt_t : width/type of the phase down-counter
//   load_value() : converts a cycle count into the counter load value
package fpga_mode_pkg;

  localparam int   CNT_W   = 16;
  localparam logic MODE_HF = 1'b1;
  localparam logic MODE_LF = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    DRAIN,
    SWITCH,
    SETTLE
  } seq_state_e;

  // A phase of N cycles ends on the cycle the counter reads 0,
  // so the counter is loaded with N-1 on entry.
  function automatic cnt_t load_value(input int unsigned cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/fpga_sync2.sv
// fpga_sync2: two-flop synchroniser for a single asynchronous bit.
//   clk       : destination clock
//   rst_n     : asynchronous active-low reset
//   d         : asynchronous input
//   q         : synchronised output (second flop)
// RESET_VAL sets the value both flops take during reset, so the
// synchronised output starts out agreeing with the caller's reset state.
module fpga_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples the pre-edge value; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/fpga_mode_sequencer.sv
// fpga_mode_sequencer: break-before-make controller for the HF/LF
// personality select of the all-in-one FPGA top level.
//
// Ports:
//   pck0      in   clock
//   nrst      in   asynchronous active-low reset
//   mode_req  in   raw FPGA_SWITCH request from the ARM, asynchronous (1 = HF)
//   ssp_busy  in   an SSP frame is in progress in the active personality
//   mode_sel  out  select line for every HF/LF output mux (1 = HF)
//   pwr_gate  out  forces pwr_lo/hi/oe1-4 and PWR_LO_EN low at the muxes
//   adc_gate  out  holds adc_noe high and adc_clk low
//   ssp_hold  out  holds ssp_frame/ssp_clk low
//   busy      out  a sequence is in progress (state != IDLE)
//
// Optional build macro FPGA_MODE_SEQ_STATUS_EN adds:
//   switch_cnt[7:0] out  saturating count of completed select flips
//   abort_seen      out  sticky flag, set when a debounce is abandoned
//
// Sequence: IDLE -> DEBOUNCE -> DRAIN -> SWITCH -> SETTLE -> IDLE.
// The three gates are asserted in DRAIN, SWITCH and SETTLE only, so the
// select can never move while a personality is driving the outputs.
// busy additionally covers DEBOUNCE, since a sequence has begun there
// even though nothing is gated yet.
module fpga_mode_sequencer
  import fpga_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned DRAIN_CYCLES    = 64,
  parameter int unsigned SETTLE_CYCLES   = 256,
  parameter logic        RESET_MODE      = MODE_HF
) (
  input  logic       pck0,
  input  logic       nrst,
  input  logic       mode_req,
  input  logic       ssp_busy,
  output logic       mode_sel,
  output logic       pwr_gate,
  output logic       adc_gate,
  output logic       ssp_hold,
  output logic       busy
`ifdef FPGA_MODE_SEQ_STATUS_EN
  ,
  output logic [7:0] switch_cnt,
  output logic       abort_seen
`endif
);

  localparam cnt_t DEBOUNCE_LOAD = load_value(DEBOUNCE_CYCLES);
  localparam cnt_t DRAIN_LOAD    = load_value(DRAIN_CYCLES);
  localparam cnt_t SETTLE_LOAD   = load_value(SETTLE_CYCLES);

  logic       req_s;
  seq_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       mode_q;
  logic       gate_q, gate_d;
  logic       busy_q;
  logic       cnt_zero;

  // The request is the only asynchronous input; it is sampled nowhere
  // else. The flops reset to RESET_MODE so no switch is requested
  // straight out of reset unless mode_req really disagrees.
  fpga_sync2 #(
    .RESET_VAL (RESET_MODE)
  ) u_req_sync (
    .clk   (pck0),
    .rst_n (nrst),
    .d     (mode_req),
    .q     (req_s)
  );

  assign cnt_zero = (cnt_q == '0);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    // Free-running decrement that parks at 0; each phase reloads on entry.
    cnt_d   = cnt_zero ? cnt_q : cnt_q - cnt_t'(1);

    unique case (state_q)
      IDLE: begin
        if (req_s != mode_q) begin
          state_d = DEBOUNCE;
          cnt_d   = DEBOUNCE_LOAD;
        end
      end
      DEBOUNCE: begin
        // Any cycle of agreement abandons the request outright.
        if (req_s == mode_q) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // Never cut an SSP frame: wait past the minimum for it to end.
        if (cnt_zero && !ssp_busy) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        // Unreachable encodings recover through a gated settle period.
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
    endcase

    gate_d = (state_d == DRAIN) || (state_d == SWITCH) || (state_d == SETTLE);
  end

  // Reset lands in SETTLE with everything gated, so the muxes get the
  // same settling time after power-up as after a switch.
  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      state_q <= SETTLE;
      cnt_q   <= SETTLE_LOAD;
      mode_q  <= RESET_MODE;
      gate_q  <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      busy_q  <= (state_d != IDLE);
      if (state_q == SWITCH) begin
        mode_q <= ~mode_q;
      end
    end
  end

  assign mode_sel = mode_q;
  assign pwr_gate = gate_q;
  assign adc_gate = gate_q;
  assign ssp_hold = gate_q;
  assign busy     = busy_q;

`ifdef FPGA_MODE_SEQ_STATUS_EN
  logic [7:0] switch_cnt_q;
  logic       abort_seen_q;
  logic       abort;

  assign abort = (state_q == DEBOUNCE) && (req_s == mode_q);

  always_ff @(posedge pck0 or negedge nrst) begin
    if (!nrst) begin
      switch_cnt_q <= 8'd0;
      abort_seen_q <= 1'b0;
    end else begin
      if ((state_q == SWITCH) && (switch_cnt_q != 8'hFF)) begin
        switch_cnt_q <= switch_cnt_q + 8'd1;
      end
      if (abort) begin
        abort_seen_q <= 1'b1;
      end
    end
  end

  assign switch_cnt = switch_cnt_q;
  assign abort_seen = abort_seen_q;
`endif

endmodule

// File: tb/tb_fpga_mode_sequencer.sv
// tb_fpga_mode_sequencer: scoreboard bench for fpga_mode_sequencer.
// A reference model, advanced on every clock edge, pushes the expected
// outputs for the coming cycle into a queue; a monitor on the falling
// edge pops one entry and compares it with the DUT. Directed scenarios
// come first, followed by randomised request/ssp_busy/reset traffic.
// Define FPGA_MODE_SEQ_STATUS_EN to also check the status outputs.
module tb_fpga_mode_sequencer;

  localparam int   DEB   = 4;
  localparam int   DRN   = 3;
  localparam int   STL   = 5;
  localparam logic RMODE = 1'b1;

  logic       pck0;
  logic       nrst;
  logic       mode_req;
  logic       ssp_busy;
  logic       mode_sel;
  logic       pwr_gate;
  logic       adc_gate;
  logic       ssp_hold;
  logic       busy;
`ifdef FPGA_MODE_SEQ_STATUS_EN
  logic [7:0] switch_cnt;
  logic       abort_seen;
`endif

  fpga_mode_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .DRAIN_CYCLES    (DRN),
    .SETTLE_CYCLES   (STL),
    .RESET_MODE      (RMODE)
  ) dut (
    .pck0       (pck0),
    .nrst       (nrst),
    .mode_req   (mode_req),
    .ssp_busy   (ssp_busy),
    .mode_sel   (mode_sel),
    .pwr_gate   (pwr_gate),
    .adc_gate   (adc_gate),
    .ssp_hold   (ssp_hold),
    .busy       (busy)
`ifdef FPGA_MODE_SEQ_STATUS_EN
    ,
    .switch_cnt (switch_cnt),
    .abort_seen (abort_seen)
`endif
  );

  initial begin
    pck0 = 1'b0;
    forever #5 pck0 = ~pck0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Described in terms of elapsed cycles rather than states:
  //   mismatch_run : consecutive ungated cycles the synced request has
  //                  disagreed with the select (0 = idle)
  //   in_seq       : gates asserted
  //   pre_cycles   : gated cycles spent draining before the flip
  //   flip_next    : drain satisfied, the next gated cycle flips the select
  //   flipped      : select already flipped in this sequence
  //   post_cycles  : gated cycles since the flip
  typedef struct packed {
    logic       mode;
    logic       gate;
    logic       busy;
    logic [7:0] sw;
    logic       ab;
  } exp_t;

  exp_t exp_q[$];
  logic m_s1, m_s2, m_mode;
  int   mismatch_run, pre_cycles, post_cycles, m_sw;
  bit   in_seq, flip_next, flipped, m_ab;
  bit   seen_edge = 1'b0;

  function automatic exp_t snapshot();
    exp_t e;
    e.mode = m_mode;
    e.gate = in_seq;
    e.busy = in_seq || (mismatch_run > 0);
    e.sw   = 8'(m_sw);
    e.ab   = m_ab;
    return e;
  endfunction

  task automatic model_reset();
    m_s1 = RMODE;  m_s2 = RMODE;  m_mode = RMODE;
    mismatch_run = 0;  pre_cycles = 0;  post_cycles = 0;
    in_seq = 1'b1;  flip_next = 1'b0;  flipped = 1'b1;
    m_sw = 0;  m_ab = 1'b0;
  endtask

  task automatic model_step(input logic req, input logic sbusy);
    if (!in_seq) begin
      if (m_s2 != m_mode) begin
        mismatch_run++;
        // The comparing idle cycle plus DEB debounce cycles all disagreed.
        if (mismatch_run == DEB + 1) begin
          mismatch_run = 0;
          in_seq       = 1'b1;
          flipped      = 1'b0;
          flip_next    = 1'b0;
          pre_cycles   = 0;
        end
      end else begin
        if (mismatch_run > 0) m_ab = 1'b1;
        mismatch_run = 0;
      end
    end else if (!flipped) begin
      if (flip_next) begin
        m_mode      = ~m_mode;
        flipped     = 1'b1;
        post_cycles = 0;
        if (m_sw < 255) m_sw++;
      end else begin
        pre_cycles++;
        if (pre_cycles >= DRN && !sbusy) flip_next = 1'b1;
      end
    end else begin
      post_cycles++;
      if (post_cycles == STL) in_seq = 1'b0;
    end
    m_s2 = m_s1;
    m_s1 = req;
  endtask

  // While reset is low the queue always holds exactly one reset entry.
  initial begin
    forever begin
      @(posedge pck0 or negedge nrst);
      seen_edge = 1'b1;
      if (!nrst) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(snapshot());
      end else begin
        model_step(mode_req, ssp_busy);
        exp_q.push_back(snapshot());
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge pck0);
      if (exp_q.size() == 0) begin
        if (seen_edge) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
        end
      end else begin
        e = exp_q.pop_front();
        check("mode_sel", 8'(mode_sel), 8'(e.mode));
        check("pwr_gate", 8'(pwr_gate), 8'(e.gate));
        check("adc_gate", 8'(adc_gate), 8'(e.gate));
        check("ssp_hold", 8'(ssp_hold), 8'(e.gate));
        check("busy",     8'(busy),     8'(e.busy));
`ifdef FPGA_MODE_SEQ_STATUS_EN
        check("switch_cnt", switch_cnt,       e.sw);
        check("abort_seen", 8'(abort_seen), 8'(e.ab));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge pck0);
    #1;
  endtask

  task automatic wait_gate(input logic level, input int budget, input string name);
    int n = 0;
    while (pwr_gate !== level && n < budget) begin
      step(1);
      n++;
    end
    check(name, 8'(pwr_gate), 8'(level));
  endtask

  task automatic wait_mode(input logic level, input int budget, input string name);
    int n = 0;
    while (mode_sel !== level && n < budget) begin
      step(1);
      n++;
    end
    check(name, 8'(mode_sel), 8'(level));
  endtask

  initial begin
    nrst     = 1'b0;
    mode_req = 1'b1;
    ssp_busy = 1'b0;
    step(3);
    nrst = 1'b1;

    // Power-up settle, no request.
    step(12);
    check("post_reset_mode", 8'(mode_sel), 8'(1));

    // Plain 1 -> 0 switch.
    mode_req = 1'b0;
    step(22);
    check("switch_to_lf", 8'(mode_sel), 8'(0));

    // Back to HF, then a short low pulse that must be debounced away.
    mode_req = 1'b1;
    step(22);
    check("back_to_hf", 8'(mode_sel), 8'(1));
    mode_req = 1'b0;
    step(3);
    mode_req = 1'b1;
    step(15);
    check("pulse_ignored", 8'(mode_sel), 8'(1));
`ifdef FPGA_MODE_SEQ_STATUS_EN
    check("abort_flag", 8'(abort_seen), 8'(1));
`endif

    // SSP frame held through the drain window, released late.
    ssp_busy = 1'b1;
    mode_req = 1'b0;
    wait_gate(1'b1, 20, "ssp_gate_rise");
    step(12);
    ssp_busy = 1'b0;
    step(20);
    check("ssp_switch_done", 8'(mode_sel), 8'(0));

    // Double toggle: request flips back during SETTLE.
    mode_req = 1'b1;
    step(22);
    mode_req = 1'b0;
    wait_mode(1'b0, 30, "dbl_first_flip");
    step(1);
    mode_req = 1'b1;
    step(40);
    check("dbl_final_mode", 8'(mode_sel), 8'(1));

    // Reset in the middle of DRAIN.
    mode_req = 1'b0;
    wait_gate(1'b1, 20, "drain_gate_rise");
    step(1);
    nrst = 1'b0;
    #1;
    check("async_rst_mode", 8'(mode_sel), 8'(1));
    check("async_rst_gate", 8'(pwr_gate), 8'(1));
    check("async_rst_busy", 8'(busy),     8'(1));
    step(2);
    nrst = 1'b1;
    step(30);
    check("rst_restart_mode", 8'(mode_sel), 8'(0));

    // Random traffic, with an occasional reset pulse.
    repeat (40) begin
      mode_req = 1'($urandom_range(0, 1));
      ssp_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        nrst = 1'b0;
        step(1);
        nrst = 1'b1;
      end
      step($urandom_range(1, 12));
    end
    ssp_busy = 1'b0;
    step(5);
    #5;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
